// File: rtl/pal_cfg_loader.sv
// PAL serial configuration transmitter: takes bitstream bytes over valid/ready and
// shifts them MSB-first onto cfg_data with a generated cfg_clk, then pulses done.
module pal_cfg_loader #(
    parameter int CFG_BITS = 280,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       cfg_clk,
    output logic       cfg_data,
    output logic       cfg_en,
    output logic       busy,
    output logic       done
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_END = CNT_W'(CFG_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, LO, HI, FIN} state_t;

    state_t           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             s_ready_q, cfg_clk_q, cfg_data_q, cfg_en_q, busy_q, done_q;
    logic             phase_end;

    assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
    assign phase_end = (div_q == DIV_LAST);

    assign s_ready  = s_ready_q;
    assign cfg_clk  = cfg_clk_q;
    assign cfg_data = cfg_data_q;
    assign cfg_en   = cfg_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Every output is a flop updated together with the state, so cfg_clk cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            s_ready_q  <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_data_q <= 1'b0;
            cfg_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q    <= IDLE;
                div_q      <= '0;
                bit_cnt_q  <= '0;
                s_ready_q  <= 1'b0;
                cfg_clk_q  <= 1'b0;
                cfg_data_q <= 1'b0;
                cfg_en_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        state_q   <= LOAD;
                        bit_cnt_q <= '0;
                        s_ready_q <= 1'b1;
                        cfg_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                    // Stalling here is legal: cfg_clk stays low and the PAL sees no edges.
                    LOAD: if (s_valid && s_ready_q) begin
                        state_q    <= LO;
                        shift_q    <= s_data;
                        cfg_data_q <= s_data[7];
                        bit_idx_q  <= '0;
                        div_q      <= '0;
                        s_ready_q  <= 1'b0;
                    end
                    LO: begin
                        if (phase_end) begin
                            state_q   <= HI;
                            div_q     <= '0;
                            cfg_clk_q <= 1'b1;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    HI: begin
                        if (phase_end) begin
                            div_q     <= '0;
                            cfg_clk_q <= 1'b0;
                            bit_cnt_q <= bit_cnt_d;
                            if (bit_cnt_d == BITS_END) begin
                                // Unsent low bits of a partial final byte are dropped here.
                                state_q    <= FIN;
                                cfg_en_q   <= 1'b0;
                                cfg_data_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else if (bit_idx_q == 3'd7) begin
                                state_q   <= LOAD;
                                s_ready_q <= 1'b1;
                            end else begin
                                state_q    <= LO;
                                shift_q    <= {shift_q[6:0], 1'b0};
                                cfg_data_q <= shift_q[6];
                                bit_idx_q  <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    FIN: begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: three parameterisations checked against a bit-timing model
// of the serial port, plus literal expectations and a PAL truth-table comparison.
module tb_pal_cfg_loader;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NI-1:0] start, abort, s_valid, s_ready, cfg_clk, cfg_data, cfg_en, busy, done;
    logic [7:0] s_data [NI];

    always #5 clk = ~clk;

    pal_cfg_loader u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .s_data(s_data[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .cfg_clk(cfg_clk[0]), .cfg_data(cfg_data[0]),
        .cfg_en(cfg_en[0]), .busy(busy[0]), .done(done[0]));
    pal_cfg_loader #(.CFG_BITS(16), .CLK_DIV(1), .CNT_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .s_data(s_data[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .cfg_clk(cfg_clk[1]), .cfg_data(cfg_data[1]),
        .cfg_en(cfg_en[1]), .busy(busy[1]), .done(done[1]));
    pal_cfg_loader #(.CFG_BITS(12), .CLK_DIV(2), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .s_data(s_data[2]),
        .s_valid(s_valid[2]), .s_ready(s_ready[2]), .cfg_clk(cfg_clk[2]), .cfg_data(cfg_data[2]),
        .cfg_en(cfg_en[2]), .busy(busy[2]), .done(done[2]));

    function automatic int cb(input int k);
        return (k == 0) ? 280 : (k == 1) ? 16 : 12;
    endfunction
    function automatic int dv(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic logic [7:0] pat(input int k, input int i);
        if (k == 1) return (i == 0) ? 8'hA5 : 8'h3C;
        if (k == 2) return (i == 0) ? 8'hFF : 8'hF0;
        if (i >= 28) return 8'(i * 37 + 11);
        case (i % 5)
            0: return 8'h80;
            1: return 8'h21;
            2: return 8'h48;
            3: return 8'h06;
            default: return 8'h00;
        endcase
    endfunction

    // PAL with N=8 inputs, P=14 products, M=4 outputs; fuse j of product p selects x[j/2] (even) or ~x[j/2] (odd).
    function automatic logic [3:0] pal_eval(input logic [279:0] f, input logic [7:0] x);
        logic [3:0] o;
        logic pt;
        o = '0;
        for (int p = 0; p < 14; p++) begin
            pt = 1'b1;
            for (int j = 0; j < 16; j++)
                if (f[p*16+j]) pt = pt & ((j % 2 == 0) ? x[j/2] : ~x[j/2]);
            for (int m = 0; m < 4; m++)
                if (f[224+p*4+m] && pt) o[m] = 1'b1;
        end
        return o;
    endfunction

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: 0 idle, 1 waiting for a byte, 2 shifting a byte (t = cycles since acceptance), 3 finish
    int         m_mode [NI];
    int         m_t    [NI];
    int         m_nb   [NI];
    int         m_sent [NI];
    logic [7:0] m_byte [NI];
    logic       m_last [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_mode[k] = 0; m_t[k] = 0; m_sent[k] = 0; m_last[k] = 1'b0;
            end else if (m_mode[k] != 0 && abort[k]) begin
                m_mode[k] = 0; m_last[k] = 1'b0;
            end else begin
                case (m_mode[k])
                    0: if (start[k] && !abort[k]) begin m_mode[k] = 1; m_sent[k] = 0; end
                    1: if (s_valid[k]) begin
                        m_byte[k] = s_data[k];
                        m_nb[k]   = (cb(k) - m_sent[k] < 8) ? cb(k) - m_sent[k] : 8;
                        m_t[k]    = 1;
                        m_mode[k] = 2;
                    end
                    2: if (m_t[k] == m_nb[k] * 2 * dv(k)) begin
                        m_sent[k] += m_nb[k];
                        m_last[k] = m_byte[k][8 - m_nb[k]];
                        if (m_sent[k] == cb(k)) begin m_mode[k] = 3; m_last[k] = 1'b0; end
                        else m_mode[k] = 1;
                    end else m_t[k]++;
                    default: m_mode[k] = 0;
                endcase
            end
        end
    end

    int   cyc = 0;
    int   n_edge [NI];
    int   n_done [NI];
    int   n_acc  [NI];
    int   e_first[NI];
    int   e_last [NI];
    logic cap    [NI][512];
    logic prv_clk[NI];
    logic [5:0] e_out;
    int   e_ph, e_ix;

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < NI; k++)
            if (rst_n && s_valid[k] && s_ready[k] && !abort[k]) n_acc[k]++;
    end

    // Output order: s_ready, cfg_clk, cfg_data, cfg_en, busy, done
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            e_out = '0;
            case (m_mode[k])
                1: e_out = {1'b1, 1'b0, m_last[k], 1'b1, 1'b1, 1'b0};
                2: begin
                    e_ph  = (m_t[k] - 1) % (2 * dv(k));
                    e_ix  = (m_t[k] - 1) / (2 * dv(k));
                    e_out = {1'b0, (e_ph >= dv(k)), m_byte[k][7 - e_ix], 1'b1, 1'b1, 1'b0};
                end
                3: e_out = 6'b000011;
                default: e_out = '0;
            endcase
            chk($sformatf("outs%0d", k),
                {26'd0, s_ready[k], cfg_clk[k], cfg_data[k], cfg_en[k], busy[k], done[k]}, {26'd0, e_out});
            if (cfg_clk[k] && !prv_clk[k]) begin
                if (n_edge[k] == 0) e_first[k] = cyc;
                e_last[k] = cyc;
                if (n_edge[k] < 512) cap[k][n_edge[k]] = cfg_data[k];
                n_edge[k]++;
            end
            prv_clk[k] = cfg_clk[k];
            if (done[k]) n_done[k]++;
        end
    end

    task automatic clr(input int k);
        n_edge[k] = 0; n_done[k] = 0; n_acc[k] = 0;
    endtask

    task automatic do_start(input int k);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int w = 0;
        s_data[k]  = b;
        s_valid[k] = 1'b1;
        while (!s_ready[k] && w < 500) begin @(posedge clk); #1; w++; end
        chk($sformatf("accept_wait%0d", k), {31'd0, (w < 500)}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int k);
        int w = 0;
        while (!done[k] && w < 3000) begin @(posedge clk); #1; w++; end
        chk($sformatf("done_wait%0d", k), {31'd0, (w < 3000)}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic full_load(input int k, input int gap);
        int nb = (cb(k) + 7) / 8;
        logic [7:0] by;
        clr(k);
        do_start(k);
        for (int i = 0; i < nb; i++) begin
            send_byte(k, pat(k, i));
            if (i == 0) begin
                start[k] = 1'b1;  // start while busy must be ignored
                @(posedge clk); #1;
                start[k] = 1'b0;
            end
            if (i == 0 && gap > 0) begin
                s_valid[k] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        s_data[k] = 8'h5A;  // s_valid stays high so a surplus fetch would be taken
        wait_done(k);
        s_valid[k] = 1'b0;
        chk($sformatf("edges%0d", k), n_edge[k], cb(k));
        chk($sformatf("bytes%0d", k), n_acc[k], nb);
        chk($sformatf("dones%0d", k), n_done[k], 1);
        for (int b = 0; b < cb(k) && b < n_edge[k]; b++) begin
            by = pat(k, b / 8);
            chk($sformatf("bit%0d_%0d", k, b), {31'd0, cap[k][b]}, {31'd0, by[7 - b % 8]});
        end
    endtask

    logic [279:0] got, gold;
    logic [15:0]  v16;
    logic [7:0]   pb;
    int           w;

    initial begin
        start = '0; abort = '0; s_valid = '0;
        for (int k = 0; k < NI; k++) begin
            s_data[k] = '0; n_edge[k] = 0; n_done[k] = 0; n_acc[k] = 0; prv_clk[k] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("rst_outs%0d", k),
                {26'd0, s_ready[k], cfg_clk[k], cfg_data[k], cfg_en[k], busy[k], done[k]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // CFG_BITS=16, CLK_DIV=1: A5 then 3C
        full_load(1, 0);
        v16 = '0;
        for (int i = 0; i < 16; i++) v16[15 - i] = cap[1][i];
        chk("seq_a53c", {16'd0, v16}, 32'h0000A53C);
        chk("edges16", n_edge[1], 16);

        // CFG_BITS=12, CLK_DIV=2: FF, F0 -> all ones, 4 cycles per bit plus one LOAD cycle at the byte boundary
        full_load(2, 0);
        v16 = '0;
        for (int i = 0; i < 12; i++) v16[i] = cap[2][i];
        chk("ones12", {16'd0, v16}, 32'h00000FFF);
        chk("bytes12", n_acc[2], 2);
        chk("span12", e_last[2] - e_first[2], 45);

        // Default params with a ~20-cycle starvation after byte 1, then PAL truth table
        full_load(0, 52);
        chk("edges280", n_edge[0], 280);
        for (int b = 0; b < 280; b++) begin
            pb = pat(0, b / 8);
            gold[b] = pb[7 - b % 8];
            got[b]  = cap[0][b];
        end
        for (int x = 0; x < 256; x++)
            chk($sformatf("pal_tt_%0d", x), {28'd0, pal_eval(got, 8'(x))}, {28'd0, pal_eval(gold, 8'(x))});

        // Abort in HI of bit 5, then a fresh load from bit 0
        clr(0);
        do_start(0);
        send_byte(0, pat(0, 0));
        s_valid[0] = 1'b0;
        w = 0;
        while (n_edge[0] < 6 && w < 200) begin @(posedge clk); #1; w++; end
        chk("abort_reach", {31'd0, (w < 200)}, 32'd1);
        chk("abort_in_hi", {31'd0, cfg_clk[0]}, 32'd1);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_outs", {29'd0, cfg_clk[0], cfg_en[0], busy[0]}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_nodone", n_done[0], 0);
        chk("abort_edges", n_edge[0], 6);
        full_load(0, 0);

        // Byte offered together with abort is dropped
        clr(2);
        do_start(2);
        s_data[2] = 8'hFF; s_valid[2] = 1'b1; abort[2] = 1'b1;
        @(posedge clk); #1;
        s_valid[2] = 1'b0; abort[2] = 1'b0;
        chk("abort_byte_acc", n_acc[2], 0);
        chk("abort_byte_busy", {31'd0, busy[2]}, 32'd0);
        full_load(2, 0);

        // Asynchronous reset in the middle of LO
        clr(0);
        do_start(0);
        send_byte(0, pat(0, 0));
        s_valid[0] = 1'b0;
        chk("pre_rst_lo", {30'd0, cfg_data[0], cfg_en[0]}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("async_rst%0d", k),
                {26'd0, s_ready[k], cfg_clk[k], cfg_data[k], cfg_en[k], busy[k], done[k]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start together with abort in IDLE stays idle
        start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; abort[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("start_abort_idle", {30'd0, busy[0], s_ready[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Transmit end of the PAL serial configuration port.
- Accepts the configuration bitstream as bytes over a valid/ready handshake and serializes them MSB-first onto the PAL's cfg line, with a generated shift clock and enable.
- Sits beside the PAL fabric and drives its cfg-clock, enable and cfg-bit inputs.
- Counts exactly CFG_BITS bits, then pulses done.

Parameters:
- CFG_BITS, 280, total bitstream length: 2*N*P AND-plane plus P*M OR-plane for N=8, P=14, M=4.
- CLK_DIV, 2, clk cycles per cfg_clk half-period (>=1).
- CNT_W, 9, width of bit counter; must satisfy 2^CNT_W > CFG_BITS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load; ignored unless idle.
- abort  in  1  cancel the load in progress.
- s_data  in  8  bitstream byte; bit 7 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte this cycle.
- cfg_clk  out  1  shift clock to PAL; target samples cfg_data on its rising edge.
- cfg_data  out  1  serial config bit.
- cfg_en  out  1  shift enable to PAL; high for the whole load, including stalls.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last bit's high phase completes.

Behaviour:
- Reset (async, any state): state=IDLE; s_ready, cfg_clk, cfg_data, cfg_en, busy, done all 0; counters 0.
- All outputs are registered.
- IDLE:
  - start=1 and abort=0 -> LOAD; cfg_en=1 and busy=1 from the next cycle.
- LOAD:
  - s_ready=1, cfg_clk=0.
  - On s_valid&s_ready: latch the byte into an 8-bit shift register and go to LO.
  - No valid byte present: stay in LOAD, cfg_clk held low, cfg_en stays 1 (stall is legal; the PAL sees no edges).
- LO:
  - cfg_data = current bit, cfg_clk=0, held for CLK_DIV cycles, then -> HI.
  - cfg_data changes only on entry to LO, so setup to the rising edge is CLK_DIV cycles and hold is CLK_DIV cycles.
- HI:
  - cfg_clk=1 for CLK_DIV cycles; bit_cnt increments at the end of HI.
  - If bit_cnt reaches CFG_BITS -> FIN.
  - Else if the byte is exhausted (8 bits sent) -> LOAD.
  - Else shift left and -> LO.
- FIN:
  - cfg_clk=0, cfg_en=0, cfg_data=0, done=1 for exactly one cycle, then -> IDLE.
- Latency: byte accepted in cycle k -> cfg_data=bit7 in cycle k+1 -> first cfg_clk rise in cycle k+1+CLK_DIV.
- Each bit occupies 2*CLK_DIV cycles.
- Partial last byte: when CFG_BITS mod 8 = r != 0, only bits 7..8-r of the final byte are sent; the remaining low bits are discarded.
- Total bytes consumed = ceil(CFG_BITS/8); no byte is requested after the final one.
- abort:
  - Any non-IDLE state -> IDLE next cycle with cfg_clk=0, cfg_en=0, s_ready=0, busy=0, and no done pulse.
  - A byte offered in the same cycle as abort is not accepted.
  - abort and start in the same cycle in IDLE: remain IDLE.
- start while busy: ignored.
- done and start in the same cycle cannot occur; start sampled in FIN is ignored.
- cfg_clk never glitches: it is driven from the state register only.

Test Plan:
- CFG_BITS=16, CLK_DIV=1; start, feed 0xA5 then 0x3C with s_valid held -> cfg_data sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 sampled at 16 cfg_clk rising edges; done pulses once; cfg_en low thereafter.
- Default params with a reference PAL model; stream 35 bytes of a known AND/OR pattern -> exactly 280 rising edges, done after the final edge, and PAL outputs match the golden truth table for all 256 inputs.
- CFG_BITS=12, CLK_DIV=2; bytes 0xFF, 0xF0 -> 12 rising edges, all bits 1, 4 cycles per bit; exactly 2 bytes accepted; s_ready never high after the 2nd byte.
- Starvation: drop s_valid for 20 cycles after byte 1 -> cfg_clk low and cfg_en high for the whole gap; no edges; resumes with bit7 of byte 2; total edge count unchanged.
- abort issued during HI of bit 5 -> next cycle cfg_clk=0, cfg_en=0, busy=0, no done; a subsequent start begins a fresh load from bit 0.
- Assert rst_n low mid-LO -> all outputs 0 asynchronously (before the next clk edge); start in IDLE with abort=1 -> stays IDLE.
